// File: rtl/ntt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ntt_ctrl_pkg
// Brief    : Shared types, core mode codes and index helper for ntt_core_ctrl.
// Revision : 1.0
// ============================================================================
package ntt_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    UNLOAD  = 3'd4
  } ctrl_state_t;

  localparam logic [1:0] MODE_NTT  = 2'd0;
  localparam logic [1:0] MODE_READ = 2'd3;
  localparam int         FIFO_DEPTH = 4;

  // Butterfly group index for a given address within stage log_m.
  function automatic logic [31:0] ntt_i_index(input logic [31:0] addr,
                                              input logic [31:0] log_m);
    return addr >> (log_m - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ntt_ctrl_fifo
// Brief    : 4-entry synchronous FIFO with occupancy count (unload buffer).
// Revision : 1.0
// ============================================================================
module ntt_ctrl_fifo
  import ntt_ctrl_pkg::*;
#(
  parameter int WIDTH = 120
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [2:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [2:0]       r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign w_pop  = pop && (r_count != 3'd0);
  assign w_push = push && ((r_count != 3'(FIFO_DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == 3'd0);

endmodule
`default_nettype wire

// File: rtl/ntt_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ntt_core_ctrl
// Brief    : Load / butterfly-sweep / unload sequencer for one ntt_core.
//            Optional cycle_count port enabled by NTT_CTRL_CYCLE_COUNT_EN.
// Revision : 1.0
// ============================================================================
module ntt_core_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int COEF_W       = 30,
  parameter int LOG_M_W      = 4,
  parameter int I_W          = 10,
  parameter int STAGES       = 9,
  parameter int CORE_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*COEF_W-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*COEF_W-1:0]   out_data,
  output logic [LOG_M_W-1:0]    log_m,
  output logic [I_W-1:0]        i,
  output logic [1:0]            mode,
  output logic [ADDR_W-1:0]     read_address,
  output logic                  upper_write_enable,
  output logic                  lower_write_enable,
  output logic [ADDR_W-1:0]     upper_write_address,
  output logic [ADDR_W-1:0]     lower_write_address,
  output logic [2*COEF_W-1:0]   upper_data_input,
  output logic [2*COEF_W-1:0]   lower_data_input,
  input  logic [COEF_W-1:0]     r1,
  input  logic [COEF_W-1:0]     r2,
  input  logic [COEF_W-1:0]     r3,
  input  logic [COEF_W-1:0]     r4
`ifdef NTT_CTRL_CYCLE_COUNT_EN
  ,
  output logic [31:0]           cycle_count
`endif
);

  localparam int                 c_depth      = 1 << ADDR_W;
  localparam int                 c_drain_w    = $clog2(CORE_LATENCY + 1);
  localparam logic [ADDR_W:0]    c_last_beat  = (ADDR_W+1)'(2 * c_depth - 1);
  localparam logic [ADDR_W:0]    c_depth_cnt  = (ADDR_W+1)'(c_depth);
  localparam logic [ADDR_W-1:0]  c_last_addr  = ADDR_W'(c_depth - 1);
  localparam logic [LOG_M_W-1:0] c_last_stage = LOG_M_W'(STAGES);
  localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(CORE_LATENCY - 1);

  ctrl_state_t           r_state;
  logic [LOG_M_W-1:0]    r_log_m;
  logic [I_W-1:0]        r_i;
  logic [1:0]            r_mode;
  logic [ADDR_W-1:0]     r_read_address;
  logic                  r_issue;
  logic [ADDR_W:0]       r_beat;
  logic [c_drain_w-1:0]  r_drain_cnt;
  logic [ADDR_W:0]       r_rd_cnt;
  logic [ADDR_W:0]       r_pop_cnt;
  logic                  r_done;
  logic [CORE_LATENCY-1:0] r_dly_vld;
  logic [ADDR_W-1:0]     r_dly_addr [CORE_LATENCY];

  logic                  w_ret_vld;
  logic [ADDR_W-1:0]     w_ret_addr;
  logic                  w_load_fire;
  logic                  w_wb;
  logic                  w_pop;
  logic [2:0]            w_fifo_count;
  logic                  w_fifo_empty;
  logic [7:0]            w_inflight;
  logic [7:0]            w_used;
  logic                  w_credit;
  logic [ADDR_W-1:0]     w_next_addr;

  // Issue tracker mirroring the core's fixed pipeline latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly_vld <= '0;
      for (int k = 0; k < CORE_LATENCY; k++) r_dly_addr[k] <= '0;
    end else begin
      r_dly_vld[0]  <= r_issue;
      r_dly_addr[0] <= r_read_address;
      for (int k = 1; k < CORE_LATENCY; k++) begin
        r_dly_vld[k]  <= r_dly_vld[k-1];
        r_dly_addr[k] <= r_dly_addr[k-1];
      end
    end
  end

  assign w_ret_vld  = r_dly_vld[CORE_LATENCY-1];
  assign w_ret_addr = r_dly_addr[CORE_LATENCY-1];

  always_comb begin
    w_inflight = 8'(r_issue);
    for (int k = 0; k < CORE_LATENCY; k++) w_inflight = w_inflight + 8'(r_dly_vld[k]);
  end

  // Reserve a FIFO slot for every read still travelling through the core.
  assign w_used      = 8'(w_fifo_count) + w_inflight;
  assign w_credit    = (w_used < 8'(FIFO_DEPTH));
  assign w_next_addr = r_read_address + ADDR_W'(1);
  assign w_pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_log_m        <= LOG_M_W'(1);
      r_i            <= '0;
      r_mode         <= MODE_NTT;
      r_read_address <= '0;
      r_issue        <= 1'b0;
      r_beat         <= '0;
      r_drain_cnt    <= '0;
      r_rd_cnt       <= '0;
      r_pop_cnt      <= '0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state        <= LOAD;
            r_beat         <= '0;
            r_log_m        <= LOG_M_W'(1);
            r_i            <= '0;
            r_mode         <= MODE_NTT;
            r_read_address <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            r_beat <= r_beat + (ADDR_W+1)'(1);
            if (r_beat == c_last_beat) begin
              r_state <= COMPUTE;
              r_issue <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (r_read_address == c_last_addr) begin
            r_state     <= DRAIN;
            r_issue     <= 1'b0;
            r_drain_cnt <= '0;
          end else begin
            r_read_address <= w_next_addr;
            r_i            <= I_W'(ntt_i_index(32'(w_next_addr), 32'(r_log_m)));
          end
        end
        DRAIN: begin
          if (r_drain_cnt == c_drain_last) begin
            r_read_address <= '0;
            if (r_log_m == c_last_stage) begin
              r_state   <= UNLOAD;
              r_mode    <= MODE_READ;
              r_rd_cnt  <= '0;
              r_pop_cnt <= '0;
            end else begin
              r_state <= COMPUTE;
              r_log_m <= r_log_m + LOG_M_W'(1);
              r_i     <= '0;
              r_issue <= 1'b1;
            end
          end else begin
            r_drain_cnt <= r_drain_cnt + c_drain_w'(1);
          end
        end
        UNLOAD: begin
          if (w_credit && (r_rd_cnt != c_depth_cnt)) begin
            r_issue        <= 1'b1;
            r_read_address <= r_rd_cnt[ADDR_W-1:0];
            r_rd_cnt       <= r_rd_cnt + (ADDR_W+1)'(1);
          end else begin
            r_issue <= 1'b0;
          end
          if (w_pop) begin
            r_pop_cnt <= r_pop_cnt + (ADDR_W+1)'(1);
            if (r_pop_cnt == c_depth_cnt - (ADDR_W+1)'(1)) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Load beats and butterfly write-backs never overlap, so one port mux serves both.
  assign w_load_fire = (r_state == LOAD) && in_valid;
  assign w_wb        = w_ret_vld && ((r_state == COMPUTE) || (r_state == DRAIN));

  assign upper_write_enable  = (w_load_fire && !r_beat[ADDR_W]) || w_wb;
  assign lower_write_enable  = (w_load_fire &&  r_beat[ADDR_W]) || w_wb;
  assign upper_write_address = w_wb ? w_ret_addr : r_beat[ADDR_W-1:0];
  assign lower_write_address = w_wb ? w_ret_addr : r_beat[ADDR_W-1:0];
  assign upper_data_input    = w_wb ? {r2, r1} : in_data;
  assign lower_data_input    = w_wb ? {r4, r3} : in_data;

  ntt_ctrl_fifo #(
    .WIDTH (4 * COEF_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_ret_vld && (r_state == UNLOAD)),
    .push_data ({r4, r3, r2, r1}),
    .pop       (w_pop),
    .head      (out_data),
    .count     (w_fifo_count),
    .empty     (w_fifo_empty)
  );

  assign out_valid    = !w_fifo_empty;
  assign in_ready     = (r_state == LOAD);
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign log_m        = r_log_m;
  assign i            = r_i;
  assign mode         = r_mode;
  assign read_address = r_read_address;

`ifdef NTT_CTRL_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_count <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_cycle_count <= '0;
    end else if (((r_state == COMPUTE) || (r_state == DRAIN)) && (r_cycle_count != 32'hFFFF_FFFF)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_core_ctrl
// Brief    : Directed bench for ntt_core_ctrl with a fixed-latency core model.
// Revision : 1.0
// ============================================================================
module tb_ntt_core_ctrl;

  localparam int ADDR_W = 2;
  localparam int COEF_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  log_m;
  logic [9:0]  i;
  logic [1:0]  mode;
  logic [1:0]  read_address;
  logic        uwe, lwe;
  logic [1:0]  uwa, lwa;
  logic [15:0] udi, ldi;
  logic [7:0]  r1, r2, r3, r4;
`ifdef NTT_CTRL_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ntt_core_ctrl #(
    .ADDR_W(2), .COEF_W(8), .LOG_M_W(4), .I_W(10), .STAGES(2), .CORE_LATENCY(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .log_m(log_m), .i(i), .mode(mode), .read_address(read_address),
    .upper_write_enable(uwe), .lower_write_enable(lwe),
    .upper_write_address(uwa), .lower_write_address(lwa),
    .upper_data_input(udi), .lower_data_input(ldi),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4)
`ifdef NTT_CTRL_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  // Behavioural core: 3-cycle read pipeline, +1 per coefficient in NTT mode.
  logic [15:0] mem_u [4];
  logic [15:0] mem_l [4];
  logic [31:0] pipe_w [3];
  logic [1:0]  pipe_m [3];
  logic [31:0] core_w;

  always @(posedge clk) begin
    if (uwe) mem_u[uwa] <= udi;
    if (lwe) mem_l[lwa] <= ldi;
    pipe_w[0] <= {mem_l[read_address], mem_u[read_address]};
    pipe_m[0] <= mode;
    pipe_w[1] <= pipe_w[0];
    pipe_m[1] <= pipe_m[0];
    pipe_w[2] <= pipe_w[1];
    pipe_m[2] <= pipe_m[1];
  end

  always_comb begin
    core_w = pipe_w[2];
    if (pipe_m[2] == 2'd0)
      core_w = {pipe_w[2][31:24] + 8'd1, pipe_w[2][23:16] + 8'd1,
                pipe_w[2][15:8] + 8'd1, pipe_w[2][7:0] + 8'd1};
  end
  assign {r4, r3, r2, r1} = core_w;

  typedef struct {
    logic        vld;
    logic [15:0] data;
    logic        uwe;
    logic        lwe;
    logic [1:0]  addr;
  } load_vec_t;

  typedef struct {
    logic [3:0] log_m;
    logic [1:0] ra;
    logic [9:0] i;
    logic       we;
    logic [1:0] waddr;
  } comp_vec_t;

  load_vec_t ltab [9];
  comp_vec_t ctab [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_we"}, 64'({uwe, lwe}), 64'd0);
    check({tag, "_log_m"}, 64'(log_m), 64'd1);
    check({tag, "_i"}, 64'(i), 64'd0);
    check({tag, "_mode"}, 64'(mode), 64'd0);
    check({tag, "_read_address"}, 64'(read_address), 64'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    next_cyc();
    start = 1'b0;
    #1;
    check("start_busy", 64'(busy), 64'd1);
    check("start_in_ready", 64'(in_ready), 64'd1);
  endtask

  // Drives the load table; returns at the first COMPUTE cycle.
  task automatic run_load();
    for (int n = 0; n < 9; n++) begin
      in_valid = ltab[n].vld;
      in_data  = ltab[n].data;
      #1;
      check("load_in_ready", 64'(in_ready), 64'd1);
      check("load_uwe", 64'(uwe), 64'(ltab[n].uwe));
      check("load_lwe", 64'(lwe), 64'(ltab[n].lwe));
      if (ltab[n].uwe) begin
        check("load_upper_addr", 64'(uwa), 64'(ltab[n].addr));
        check("load_upper_data", 64'(udi), 64'(ltab[n].data));
      end
      if (ltab[n].lwe) begin
        check("load_lower_addr", 64'(lwa), 64'(ltab[n].addr));
        check("load_lower_data", 64'(ldi), 64'(ltab[n].data));
      end
      next_cyc();
    end
    in_valid = 1'b0;
    #1;
    check("load_in_ready_drop", 64'(in_ready), 64'd0);
    for (int a = 0; a < 4; a++) begin
      check("load_mem_upper", 64'(mem_u[a]), 64'({8'(a), 8'(a)}));
      check("load_mem_lower", 64'(mem_l[a]), 64'({8'(a + 4), 8'(a + 4)}));
    end
  endtask

  task automatic run_unload(input int hold);
    logic [31:0] held;
    logic        seen;
    int          n;
    seen = 1'b0;
    held = '0;
    n = 0;
    out_ready = 1'b0;
    for (int c = 0; c < hold; c++) begin
      if (seen) begin
        check("bp_valid_held", 64'(out_valid), 64'd1);
        check("bp_data_stable", 64'(out_data), 64'(held));
      end else if (out_valid) begin
        seen = 1'b1;
        held = out_data;
      end
      next_cyc();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 60 && n < 4; c++) begin
      if (out_valid) begin
        check("unload_word", 64'(out_data),
              64'({8'(n + 6), 8'(n + 6), 8'(n + 2), 8'(n + 2)}));
        n++;
      end
      next_cyc();
    end
    out_ready = 1'b0;
    check("unload_word_count", 64'(n), 64'd4);
    check("done_pulse", 64'(done), 64'd1);
    check("done_idle", 64'(busy), 64'd0);
    next_cyc();
    check("done_single", 64'(done), 64'd0);
    check("no_extra_word", 64'(out_valid), 64'd0);
  endtask

  initial begin
    ltab[0] = '{1'b1, 16'h0000, 1'b1, 1'b0, 2'd0};
    ltab[1] = '{1'b1, 16'h0101, 1'b1, 1'b0, 2'd1};
    ltab[2] = '{1'b1, 16'h0202, 1'b1, 1'b0, 2'd2};
    ltab[3] = '{1'b0, 16'hAAAA, 1'b0, 1'b0, 2'd0};
    ltab[4] = '{1'b1, 16'h0303, 1'b1, 1'b0, 2'd3};
    ltab[5] = '{1'b1, 16'h0404, 1'b0, 1'b1, 2'd0};
    ltab[6] = '{1'b1, 16'h0505, 1'b0, 1'b1, 2'd1};
    ltab[7] = '{1'b1, 16'h0606, 1'b0, 1'b1, 2'd2};
    ltab[8] = '{1'b1, 16'h0707, 1'b0, 1'b1, 2'd3};

    ctab[0]  = '{4'd1, 2'd0, 10'd0, 1'b0, 2'd0};
    ctab[1]  = '{4'd1, 2'd1, 10'd1, 1'b0, 2'd0};
    ctab[2]  = '{4'd1, 2'd2, 10'd2, 1'b0, 2'd0};
    ctab[3]  = '{4'd1, 2'd3, 10'd3, 1'b1, 2'd0};
    ctab[4]  = '{4'd1, 2'd3, 10'd3, 1'b1, 2'd1};
    ctab[5]  = '{4'd1, 2'd3, 10'd3, 1'b1, 2'd2};
    ctab[6]  = '{4'd1, 2'd3, 10'd3, 1'b1, 2'd3};
    ctab[7]  = '{4'd2, 2'd0, 10'd0, 1'b0, 2'd0};
    ctab[8]  = '{4'd2, 2'd1, 10'd0, 1'b0, 2'd0};
    ctab[9]  = '{4'd2, 2'd2, 10'd1, 1'b0, 2'd0};
    ctab[10] = '{4'd2, 2'd3, 10'd1, 1'b1, 2'd0};
    ctab[11] = '{4'd2, 2'd3, 10'd1, 1'b1, 2'd1};
    ctab[12] = '{4'd2, 2'd3, 10'd1, 1'b1, 2'd2};
    ctab[13] = '{4'd2, 2'd3, 10'd1, 1'b1, 2'd3};

    rst = 1'b1;
    repeat (3) next_cyc();
    rst = 1'b0;
    #1;
    check_reset_state("reset");

    // Run 1: full sequence with cycle-exact compute trace.
    do_start();
    run_load();
    for (int n = 0; n < 14; n++) begin
      logic [7:0] v;
      v = 8'(ctab[n].waddr) + 8'(ctab[n].log_m);
      check("comp_busy", 64'(busy), 64'd1);
      check("comp_mode", 64'(mode), 64'd0);
      check("comp_log_m", 64'(log_m), 64'(ctab[n].log_m));
      check("comp_read_address", 64'(read_address), 64'(ctab[n].ra));
      check("comp_i", 64'(i), 64'(ctab[n].i));
      check("comp_we", 64'({uwe, lwe}), ctab[n].we ? 64'd3 : 64'd0);
      if (ctab[n].we) begin
        check("comp_upper_addr", 64'(uwa), 64'(ctab[n].waddr));
        check("comp_lower_addr", 64'(lwa), 64'(ctab[n].waddr));
        check("comp_upper_data", 64'(udi), 64'({v, v}));
        check("comp_lower_data", 64'(ldi), 64'({v + 8'd4, v + 8'd4}));
      end
      next_cyc();
    end
    check("unload_mode", 64'(mode), 64'd3);
    check("unload_we", 64'({uwe, lwe}), 64'd0);
    run_unload(0);
`ifdef NTT_CTRL_CYCLE_COUNT_EN
    check("cycle_count", 64'(cycle_count), 64'd14);
`endif

    // Run 2: start ignored while busy, then 10 cycles of output backpressure.
    do_start();
    run_load();
    next_cyc();
    start = 1'b1;
    next_cyc();
    start = 1'b0;
    #1;
    check("start_ignored_busy", 64'(busy), 64'd1);
    check("start_ignored_in_ready", 64'(in_ready), 64'd0);
    for (int c = 0; c < 100 && mode != 2'd3; c++) next_cyc();
    check("reach_unload", 64'(mode), 64'd3);
    run_unload(10);
`ifdef NTT_CTRL_CYCLE_COUNT_EN
    check("cycle_count_run2", 64'(cycle_count), 64'd14);
`endif

    // Run 3: reset mid-COMPUTE aborts with no further writes.
    do_start();
    run_load();
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    #1;
    check_reset_state("abort");
    for (int c = 0; c < 4; c++) begin
      next_cyc();
      check("abort_no_write", 64'({uwe, lwe}), 64'd0);
      check("abort_idle", 64'(busy), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_core_ctrl.md
Name: ntt_core_ctrl

Overview:
Sequencing master for one ntt_core instance. It drives the core's control and write ports (log_m, i, read_address, mode, upper/lower write address/enable/data) and consumes its r1..r4 results.
- Loads a coefficient block through a valid/ready stream.
- Runs all butterfly stages with in-place write-back of r1..r4.
- Streams the transformed block out.
It sits between the top-level DMA/stream fabric and each ntt_core, one controller per core.

Parameters:
ADDR_W, 9, core memory address width; DEPTH = 2^ADDR_W words per half-memory
COEF_W, 30, coefficient width; memory word = 2*COEF_W
LOG_M_W, 4, width of log_m
I_W, 10, width of i
STAGES, 9, number of butterfly stages; log_m runs 1..STAGES
CORE_LATENCY, 3, cycles from read_address to valid r1..r4 (fixed, no stall)
MODE_NTT, 0, core mode code for butterfly compute
MODE_READ, 3, core mode code for plain read-out

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last output word is accepted
in_valid  in  1  input stream valid
in_ready  out  1  input stream ready
in_data  in  2*COEF_W  coefficient pair {hi, lo}
out_valid  out  1  output stream valid
out_ready  in  1  output stream ready
out_data  out  4*COEF_W  {r4, r3, r2, r1}
log_m  out  LOG_M_W  to core
i  out  I_W  to core
mode  out  2  to core
read_address  out  ADDR_W  to core
upper_write_enable / lower_write_enable  out  1  to core
upper_write_address / lower_write_address  out  ADDR_W  to core
upper_data_input / lower_data_input  out  2*COEF_W  to core
r1, r2, r3, r4  in  COEF_W  from core

Behaviour:
Clocking and reset:
- Single clock clk.
- rst is synchronous, active-high. On rst: state=IDLE, busy=0, done=0, in_ready=0, out_valid=0, both write enables=0, log_m=1, i=0, mode=MODE_NTT, read_address=0, all counters and FIFO cleared.
- rst mid-operation aborts immediately; no partial write is issued after the reset edge.

States:
- IDLE -> LOAD on start.
- LOAD:
  - in_ready=1.
  - Each accepted beat (in_valid & in_ready): beats 0..DEPTH-1 write upper_write_address=beat index, upper_data_input=in_data, upper_write_enable=1 in the same cycle; beats DEPTH..2*DEPTH-1 write the lower memory at beat-DEPTH.
  - No write when in_valid=0.
  - After beat 2*DEPTH-1 -> COMPUTE with log_m=1.
- COMPUTE:
  - mode=MODE_NTT.
  - read_address sweeps 0..DEPTH-1, one per cycle, no gaps.
  - i = read_address >> (log_m-1), zero-extended/truncated to I_W.
  - A CORE_LATENCY-deep delay line carries address and issue-valid.
  - When the delayed valid is high: upper_write_address = lower_write_address = delayed address, upper_data_input={r2,r1}, lower_data_input={r4,r3}, both enables=1.
  - After the last issue -> DRAIN.
- DRAIN:
  - Waits exactly CORE_LATENCY cycles for write-backs to retire; this is the RAW barrier between stages.
  - Then if log_m==STAGES -> UNLOAD, else log_m+1 and -> COMPUTE.
- UNLOAD:
  - mode=MODE_READ, write enables=0.
  - Reads are issued only while credits > 0. Credits = 4 - FIFO occupancy - reads in flight; FIFO depth 4 >= CORE_LATENCY+1.
  - Each returned {r4,r3,r2,r1} is pushed into the FIFO; out_* is the FIFO head.
  - After DEPTH words are popped: done pulses and -> IDLE.
- start is ignored while busy=1.

Stream rules:
- out_valid must not drop without a handshake.
- out_data stays stable while out_valid & !out_ready.

Boundary cases:
- Simultaneous push and pop with the FIFO full is legal.
- The last address wraps to 0 only at a stage change.

Optional Feature:
NTT_CTRL_CYCLE_COUNT_EN:
- When defined, adds output port cycle_count (32 bits). It clears on accepted start, increments every cycle in COMPUTE and DRAIN, saturates at all-ones, and holds after done.
- When undefined, the port and counter do not exist.

Decomposition:
- Package ntt_ctrl_pkg: state enum {IDLE, LOAD, COMPUTE, DRAIN, UNLOAD}, MODE_NTT/MODE_READ codes, helper function for i derivation.
- One sub-module: ntt_ctrl_fifo, a 4-entry synchronous FIFO with count output, used for the unload buffer.

Test Plan:
Bench uses ADDR_W=2, STAGES=2, CORE_LATENCY=3 and a behavioural core model: fixed latency, r1..r4 = read words; in NTT mode each coefficient +1.
1. Load: start, 8 beats with in_data = beat index {k,k} -> upper addresses 0..3 hold {0,0}..{3,3}, lower addresses 0..3 hold {4,4}..{7,7}; in_ready drops after beat 7.
2. Compute ordering: log_m=1 sweep reads 0,1,2,3; writes to addresses 0..3 appear exactly 3 cycles later; DRAIN lasts 3 cycles; log_m=2 with i = 0,0,1,1.
3. Unload: out_ready=1 -> 4 words, each coefficient = load value + 2 (two stages); done pulses once; busy=0 the next cycle.
4. Backpressure: out_ready low for 10 cycles in UNLOAD -> out_valid held, out_data stable, at most 4 words buffered, no word lost or duplicated.
5. Robustness: rst asserted mid-COMPUTE -> next cycle all enables 0 and state IDLE; start while busy -> ignored, sequence unaffected.
6. With NTT_CTRL_CYCLE_COUNT_EN: cycle_count = 2*(4+3) = 14 after done.
